// File: rtl/tron_trail_engine.sv
// Light-cycle engine: moves one head across a 160x120 field, checks it against an occupancy
// bitmap and drives a vga_adapter plot port. Define TRON_WRAP_EN to wrap at the screen edges.
module tron_trail_engine #(
   parameter logic [7:0]  X_START   = 8'd40,
   parameter logic [6:0]  Y_START   = 7'd60,
   parameter logic [2:0]  TRAIL_COL = 3'b010,
   parameter logic [2:0]  CRASH_COL = 3'b100,
   parameter int unsigned TICK_DIV  = 2500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] dir_in,
   input  logic       dir_valid,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour_out,
   output logic       plot,
   output logic       alive,
   output logic       crashed
);

   localparam int unsigned NumPix = 19200;
   localparam int unsigned CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
   localparam logic [7:0] XMax = 8'd159;
   localparam logic [6:0] YMax = 7'd119;

   typedef enum logic [2:0] {
      StClear,
      StIdle,
      StWaitTick,
      StStep,
      StCheck,
      StDraw,
      StCrash,
      StDead
   } state_e;

   state_e          state_q;
   logic [7:0]      head_x_q, nxt_x_q, clr_x_q, x_q;
   logic [6:0]      head_y_q, nxt_y_q, clr_y_q, y_q;
   logic [1:0]      cur_dir_q, pend_dir_q;
   logic [CntW-1:0] cnt_q;
   logic [2:0]      col_q;
   logic            plot_q, alive_q, crashed_q;

   logic            occ_mem [0:NumPix-1];
   logic            occ_rd_q;
   logic            occ_we, occ_wdata;
   logic [14:0]     occ_waddr, occ_raddr;

   logic [1:0]        eff_dir;
   logic signed [8:0] sx, sy;
   logic              off_screen;
   logic [7:0]        step_x;
   logic [6:0]        step_y;

   function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
      return 15'(y) * 15'd160 + 15'(x);
   endfunction

   // Candidate next head position; a 180-degree reversal keeps the current heading.
   always_comb begin
      eff_dir = (pend_dir_q == (cur_dir_q ^ 2'b10)) ? cur_dir_q : pend_dir_q;
      sx = $signed({1'b0, head_x_q});
      sy = $signed({2'b00, head_y_q});
      unique case (eff_dir)
         2'b00: sy = sy - 9'sd1;
         2'b01: sx = sx + 9'sd1;
         2'b10: sy = sy + 9'sd1;
         2'b11: sx = sx - 9'sd1;
      endcase
`ifdef TRON_WRAP_EN
      if (sx < 9'sd0) begin
         sx = 9'sd159;
      end else if (sx > 9'sd159) begin
         sx = 9'sd0;
      end
      if (sy < 9'sd0) begin
         sy = 9'sd119;
      end else if (sy > 9'sd119) begin
         sy = 9'sd0;
      end
      off_screen = 1'b0;
`else
      off_screen = (sx < 9'sd0) || (sx > 9'sd159) || (sy < 9'sd0) || (sy > 9'sd119);
`endif
      step_x = sx[7:0];
      step_y = sy[6:0];
   end

   always_comb begin
      occ_we    = 1'b0;
      occ_wdata = 1'b1;
      occ_waddr = pix_addr(head_x_q, head_y_q);
      unique case (state_q)
         StClear: begin
            occ_we    = 1'b1;
            occ_wdata = 1'b0;
            occ_waddr = pix_addr(clr_x_q, clr_y_q);
         end
         StIdle: occ_we = start;
         StDraw: begin
            occ_we    = 1'b1;
            occ_waddr = pix_addr(nxt_x_q, nxt_y_q);
         end
         default: ;
      endcase
      // Off-screen candidates never reach CHECK; keep the read address in range anyway.
      occ_raddr = off_screen ? 15'd0 : pix_addr(step_x, step_y);
   end

   always_ff @(posedge clk) begin
      if (occ_we) begin
         occ_mem[occ_waddr] <= occ_wdata;
      end
      occ_rd_q <= occ_mem[occ_raddr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StClear;
         head_x_q   <= X_START;
         head_y_q   <= Y_START;
         nxt_x_q    <= 8'd0;
         nxt_y_q    <= 7'd0;
         clr_x_q    <= 8'd0;
         clr_y_q    <= 7'd0;
         cur_dir_q  <= 2'b01;
         pend_dir_q <= 2'b01;
         cnt_q      <= '0;
         x_q        <= 8'd0;
         y_q        <= 7'd0;
         col_q      <= 3'b000;
         plot_q     <= 1'b0;
         alive_q    <= 1'b0;
         crashed_q  <= 1'b0;
      end else begin
         plot_q <= 1'b0;
         if (dir_valid) begin
            pend_dir_q <= dir_in;
         end
         unique case (state_q)
            StClear: begin
               plot_q <= 1'b1;
               x_q    <= clr_x_q;
               y_q    <= clr_y_q;
               col_q  <= 3'b000;
               if (clr_x_q == XMax) begin
                  clr_x_q <= 8'd0;
                  if (clr_y_q == YMax) begin
                     clr_y_q <= 7'd0;
                     state_q <= StIdle;
                  end else begin
                     clr_y_q <= clr_y_q + 7'd1;
                  end
               end else begin
                  clr_x_q <= clr_x_q + 8'd1;
               end
            end
            StIdle: begin
               if (start) begin
                  plot_q  <= 1'b1;
                  x_q     <= head_x_q;
                  y_q     <= head_y_q;
                  col_q   <= TRAIL_COL;
                  cnt_q   <= '0;
                  alive_q <= 1'b1;
                  state_q <= StWaitTick;
               end
            end
            StWaitTick: begin
               if (cnt_q == CntLast) begin
                  cnt_q   <= '0;
                  state_q <= StStep;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStep: begin
               cur_dir_q <= eff_dir;
               nxt_x_q   <= step_x;
               nxt_y_q   <= step_y;
               if (off_screen) begin
                  alive_q <= 1'b0;
                  state_q <= StCrash;
               end else begin
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               if (occ_rd_q) begin
                  alive_q <= 1'b0;
                  state_q <= StCrash;
               end else begin
                  state_q <= StDraw;
               end
            end
            StDraw: begin
               head_x_q <= nxt_x_q;
               head_y_q <= nxt_y_q;
               plot_q   <= 1'b1;
               x_q      <= nxt_x_q;
               y_q      <= nxt_y_q;
               col_q    <= TRAIL_COL;
               cnt_q    <= '0;
               state_q  <= StWaitTick;
            end
            StCrash: begin
               plot_q    <= 1'b1;
               x_q       <= head_x_q;
               y_q       <= head_y_q;
               col_q     <= CRASH_COL;
               crashed_q <= 1'b1;
               state_q   <= StDead;
            end
            StDead: ;
         endcase
      end
   end

   assign x_out      = x_q;
   assign y_out      = y_q;
   assign colour_out = col_q;
   assign plot       = plot_q;
   assign alive      = alive_q;
   assign crashed    = crashed_q;

endmodule

// File: tb/tb_tron_trail_engine.sv
// Bench for tron_trail_engine: scripted game table, STEP-cycle strobe, edge, async reset and a
// randomised game checked against a grid-level model. Honours TRON_WRAP_EN.
module tb_tron_trail_engine;

   localparam int unsigned TickDiv = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] dir_in = 2'b00;
   logic       dir_valid = 1'b0;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic       plot, alive, crashed;

   int total = 0;
   int bad = 0;

   tron_trail_engine #(
      .TICK_DIV(TickDiv)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dir_in    (dir_in),
      .dir_valid (dir_valid),
      .x_out     (x_out),
      .y_out     (y_out),
      .colour_out(colour_out),
      .plot      (plot),
      .alive     (alive),
      .crashed   (crashed)
   );

   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Grid-level reference model
   bit occ [0:159][0:119];
   int hx, hy, cd, pd;
   int dxs [4] = '{0, 1, 0, -1};
   int dys [4] = '{-1, 0, 1, 0};

   task automatic model_reset();
      for (int x = 0; x < 160; x++) begin
         for (int y = 0; y < 120; y++) occ[x][y] = 1'b0;
      end
      hx = 40; hy = 60; cd = 1; pd = 1;
      occ[hx][hy] = 1'b1;
   endtask

   task automatic model_move(output int ex, output int ey, output int ec, output bit crash);
      int nx, ny;
      if (pd != (cd + 2) % 4) cd = pd;
      nx = hx + dxs[cd];
      ny = hy + dys[cd];
`ifdef TRON_WRAP_EN
      nx = (nx + 160) % 160;
      ny = (ny + 120) % 120;
`endif
      crash = 1'b0;
      if (nx < 0 || nx > 159 || ny < 0 || ny > 119) crash = 1'b1;
      else if (occ[nx][ny]) crash = 1'b1;
      if (crash) begin
         ex = hx; ey = hy; ec = 4;
      end else begin
         occ[nx][ny] = 1'b1;
         hx = nx; hy = ny;
         ex = nx; ey = ny; ec = 2;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic sweep_check(input string name);
      int first_bad = -1;
      for (int i = 0; i < 19200; i++) begin
         @(negedge clk);
         if (first_bad < 0 && !(plot === 1'b1 && int'(x_out) == i % 160 &&
                                int'(y_out) == i / 160 && colour_out == 3'b000))
            first_bad = i;
      end
      total++;
      if (first_bad >= 0) begin
         bad++;
         $display("FAIL %s: sweep deviates at pixel %0d (x=%0d y=%0d plot=%0d col=%0d)",
                  name, first_bad, x_out, y_out, plot, colour_out);
      end
      @(negedge clk);
      check({name, " plot after sweep"}, plot, 0);
      check({name, " alive after sweep"}, alive, 0);
      check({name, " crashed after sweep"}, crashed, 0);
   endtask

   task automatic start_game(input string name);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({name, " start plot"}, plot, 1);
      check({name, " start x"}, x_out, 40);
      check({name, " start y"}, y_out, 60);
      check({name, " start colour"}, colour_out, 2);
      check({name, " alive"}, alive, 1);
      model_reset();
   endtask

   // Waits for the next plot, driving nstb direction strobes from cycle 'at' on.
   task automatic move(input int nstb, input logic [5:0] dirs, input int at,
                       output int px, output int py, output int pc, output int cyc,
                       output bit got);
      got = 1'b0; cyc = 0; px = -1; py = -1; pc = -1;
      while (!got && cyc < 40) begin
         if (cyc >= at && cyc < at + nstb) begin
            dir_in    = dirs[2*(cyc-at) +: 2];
            dir_valid = 1'b1;
         end else begin
            dir_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (plot) begin
            got = 1'b1; px = int'(x_out); py = int'(y_out); pc = int'(colour_out);
         end
      end
      dir_valid = 1'b0;
   endtask

   typedef struct {
      int         nstb;
      logic [5:0] dirs;
      int         ex;
      int         ey;
      int         ec;
   } vec_t;

   initial begin
      vec_t tab [7];
      int px, py, pc, cyc, ex, ey, ec, nplots;
      bit got, crash;
      logic [5:0] dirs;
      int nstb;

      tab[0] = '{0, 6'b000000, 41, 60, 2};
      tab[1] = '{0, 6'b000000, 42, 60, 2};
      tab[2] = '{2, 6'b000110, 43, 60, 2};  // down then right: last strobe wins
      tab[3] = '{1, 6'b000011, 44, 60, 2};  // reverse ignored
      tab[4] = '{1, 6'b000000, 44, 59, 2};
      tab[5] = '{1, 6'b000011, 43, 59, 2};
      tab[6] = '{1, 6'b000010, 43, 59, 4};  // down onto own trail

      // Phase A: clear sweep, scripted game ending in a self-collision
      repeat (2) @(negedge clk);
      check("reset plot", plot, 0);
      check("reset x", x_out, 0);
      check("reset alive", alive, 0);
      check("reset crashed", crashed, 0);
      reset = 1'b0;
      sweep_check("sweep1");
      start_game("gameA");
      for (int i = 0; i < 7; i++) begin
         move(tab[i].nstb, tab[i].dirs, 0, px, py, pc, cyc, got);
         check($sformatf("tab%0d got plot", i), got, 1);
         check($sformatf("tab%0d x", i), px, tab[i].ex);
         check($sformatf("tab%0d y", i), py, tab[i].ey);
         check($sformatf("tab%0d colour", i), pc, tab[i].ec);
         check($sformatf("tab%0d interval", i), cyc, 11);
      end
      @(negedge clk);
      check("dead plot", plot, 0);
      check("dead crashed", crashed, 1);
      check("dead alive", alive, 0);
      start = 1'b1;
      nplots = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (plot) nplots++;
      end
      start = 1'b0;
      check("dead ignores start", nplots, 0);
      check("dead sticky", crashed, 1);

      // Phase B: strobe in STEP cycle, then async reset during WAIT_TICK
      do_reset();
      sweep_check("sweep2");
      start_game("gameB");
      move(1, 6'b000000, 8, px, py, pc, cyc, got);
      model_move(ex, ey, ec, crash);
      pd = 0;
      check("step strobe deferred x", px, ex);
      check("step strobe deferred y", py, ey);
      check("step strobe interval", cyc, 11);
      move(0, 6'b000000, 0, px, py, pc, cyc, got);
      model_move(ex, ey, ec, crash);
      check("step strobe applied x", px, ex);
      check("step strobe applied y", py, ey);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async reset plot", plot, 0);
      check("async reset x", x_out, 0);
      check("async reset y", y_out, 0);
      check("async reset colour", colour_out, 0);
      check("async reset alive", alive, 0);
      check("async reset crashed", crashed, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sweep_check("sweep3");

      // Phase C: run right into the x=159 edge
      start_game("gameC");
      for (int k = 0; k < 120; k++) begin
         move(0, 6'b000000, 0, px, py, pc, cyc, got);
         model_move(ex, ey, ec, crash);
         if (px != ex || py != ey || pc != ec)
            check($sformatf("edge run move %0d", k), px * 100000 + py * 10 + pc,
                  ex * 100000 + ey * 10 + ec);
         else total++;
      end
`ifdef TRON_WRAP_EN
      check("edge wrap x", px, 0);
      check("edge wrap y", py, 60);
      check("edge wrap colour", pc, 2);
`else
      check("edge crash x", px, 159);
      check("edge crash y", py, 60);
      check("edge crash colour", pc, 4);
      @(negedge clk);
      check("edge crashed", crashed, 1);
`endif

      // Phase D: randomised game against the model
      do_reset();
      sweep_check("sweep4");
      start_game("gameD");
      for (int k = 0; k < 50; k++) begin
         nstb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         dirs = 6'($urandom);
         for (int j = 0; j < nstb; j++) pd = int'(dirs[2*j +: 2]);
         move(nstb, dirs, 0, px, py, pc, cyc, got);
         model_move(ex, ey, ec, crash);
         check($sformatf("rnd%0d x", k), px, ex);
         check($sformatf("rnd%0d y", k), py, ey);
         check($sformatf("rnd%0d colour", k), pc, ec);
         if (crash) begin
            @(negedge clk);
            check($sformatf("rnd%0d crashed", k), crashed, 1);
            break;
         end
         check($sformatf("rnd%0d interval", k), cyc, 11);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
